// File: rtl/ws2812_pkg.sv
// Shared constants and state encodings for the WS2812 frame loader.
package ws2812_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         BITS_PER_LED      = 24;
   localparam int         RESTART_CYCLES    = 64;

   typedef enum logic [1:0] {
      RX_HUNT,
      RX_PAYLOAD,
      RX_CHECK,
      RX_COMMIT
   } rx_state_t;

   typedef enum logic [1:0] {
      SD_IDLE,
      SD_START,
      SD_WAIT_LO,
      SD_WAIT_HI
   } sd_state_t;

endpackage

// File: rtl/ws2812_ready_sync.sv
// Two-flop synchroniser for the driver's ready flag; output is 0 during reset.
module ws2812_ready_sync (
   input  logic i_Clock,
   input  logic i_Reset_n,
   input  logic i_Async,
   output logic o_Sync
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= i_Async;
         sync_q <= meta_q;
      end
   end

   assign o_Sync = sync_q;

endmodule

// File: rtl/ws2812_frame_loader.sv
// Assembles sync-framed UART packets into a double-buffered WS2812 frame.
// Optional trailing XOR checksum byte enabled by WS2812_FRAME_CHECKSUM_EN.
//
// rx state   | meaning
// RX_HUNT    | waiting for SYNC_BYTE
// RX_PAYLOAD | collecting NUM_LEDS*3 payload bytes
// RX_CHECK   | waiting for the checksum byte (checksum build only)
// RX_COMMIT  | copy work buffer into pending buffer
//
// send state | meaning
// SD_IDLE    | waiting for a pending frame and an idle driver
// SD_START   | o_Start asserted
// SD_WAIT_LO | waiting for the driver to drop ready; restarts every 64 cycles
// SD_WAIT_HI | waiting for the driver to finish
module ws2812_frame_loader
   import ws2812_pkg::*;
#(
   parameter int         CLOCK_FREQUENCY = 100000000,
   parameter int         NUM_LEDS        = 3,
   parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_US      = 1000
) (
   input  logic                           i_Clock,
   input  logic                           i_Reset_n,
   input  logic                           i_Rx_DV,
   input  logic [7:0]                     i_Rx_Byte,
   input  logic                           i_Ready,
   output logic                           o_Start,
   output logic [NUM_LEDS*BITS_PER_LED-1:0] o_Frame,
   output logic                           o_Busy,
   output logic                           o_Overrun,
   output logic                           o_Error
);

   localparam int FRAME_W   = NUM_LEDS * BITS_PER_LED;
   localparam int NUM_BYTES = NUM_LEDS * 3;
   localparam int IDX_W     = $clog2(NUM_BYTES);
   localparam int TO_CYCLES = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
   localparam int GAP_W     = $clog2(TO_CYCLES);
   localparam int REP_W     = $clog2(RESTART_CYCLES);

   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TO_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BYTES - 1);
   // START occupies one cycle, so WAIT_LO counts the remaining 63.
   localparam logic [REP_W-1:0] REP_LOAD  = REP_W'(RESTART_CYCLES - 2);

   rx_state_t          rx_q, rx_d;
   sd_state_t          sd_q, sd_d;
   logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [FRAME_W-1:0] work_q, work_d;
   logic [FRAME_W-1:0] pend_q, pend_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               pending_q, pending_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic               err_q, err_d;
   logic               ovr_q, ovr_d;
   logic               rdy_s;
   logic               timeout;
`ifdef WS2812_FRAME_CHECKSUM_EN
   logic [7:0]         xor_q, xor_d;
`endif

   ws2812_ready_sync u_ready_sync (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .i_Async   (i_Ready),
      .o_Sync    (rdy_s)
   );

   assign timeout = (gap_q == GAP_LAST) && !i_Rx_DV;

   always_comb begin
      rx_d       = rx_q;
      sd_d       = sd_q;
      byte_idx_d = byte_idx_q;
      gap_d      = gap_q;
      work_d     = work_q;
      pend_d     = pend_q;
      frame_d    = frame_q;
      pending_d  = pending_q;
      rep_d      = rep_q;
      err_d      = 1'b0;
      ovr_d      = 1'b0;
`ifdef WS2812_FRAME_CHECKSUM_EN
      xor_d      = xor_q;
`endif

      if (i_Rx_DV) begin
         gap_d = '0;
      end else if (gap_q != GAP_LAST) begin
         gap_d = gap_q + 1'b1;
      end

      case (rx_q)
         RX_HUNT: begin
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
               byte_idx_d = '0;
               rx_d       = RX_PAYLOAD;
`ifdef WS2812_FRAME_CHECKSUM_EN
               xor_d      = '0;
`endif
            end
         end
         RX_PAYLOAD: begin
            if (i_Rx_DV) begin
               for (int i = 0; i < NUM_BYTES; i++) begin
                  if (byte_idx_q == IDX_W'(i)) begin
                     work_d[8*(NUM_BYTES-1-i) +: 8] = i_Rx_Byte;
                  end
               end
               byte_idx_d = byte_idx_q + 1'b1;
`ifdef WS2812_FRAME_CHECKSUM_EN
               xor_d = xor_q ^ i_Rx_Byte;
               if (byte_idx_q == IDX_LAST) rx_d = RX_CHECK;
`else
               if (byte_idx_q == IDX_LAST) rx_d = RX_COMMIT;
`endif
            end else if (timeout) begin
               err_d = 1'b1;
               rx_d  = RX_HUNT;
            end
         end
         RX_CHECK: begin
`ifdef WS2812_FRAME_CHECKSUM_EN
            if (i_Rx_DV) begin
               if (i_Rx_Byte == xor_q) begin
                  rx_d = RX_COMMIT;
               end else begin
                  err_d = 1'b1;
                  rx_d  = RX_HUNT;
               end
            end else if (timeout) begin
               err_d = 1'b1;
               rx_d  = RX_HUNT;
            end
`else
            rx_d = RX_HUNT;
`endif
         end
         RX_COMMIT: begin
            pend_d    = work_q;
            ovr_d     = pending_q;
            pending_d = 1'b1;
            rx_d      = RX_HUNT;
         end
         default: rx_d = RX_HUNT;
      endcase

      // A commit in the same cycle takes priority; the transfer retries next cycle.
      case (sd_q)
         SD_IDLE: begin
            if (pending_q && rdy_s && (rx_q != RX_COMMIT)) begin
               frame_d   = pend_q;
               pending_d = 1'b0;
               sd_d      = SD_START;
            end
         end
         SD_START: begin
            rep_d = REP_LOAD;
            sd_d  = SD_WAIT_LO;
         end
         SD_WAIT_LO: begin
            if (!rdy_s) begin
               sd_d = SD_WAIT_HI;
            end else if (rep_q == '0) begin
               sd_d = SD_START;
            end else begin
               rep_d = rep_q - 1'b1;
            end
         end
         SD_WAIT_HI: begin
            if (rdy_s) sd_d = SD_IDLE;
         end
         default: sd_d = SD_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         rx_q       <= RX_HUNT;
         sd_q       <= SD_IDLE;
         byte_idx_q <= '0;
         gap_q      <= '0;
         work_q     <= '0;
         pend_q     <= '0;
         frame_q    <= '0;
         pending_q  <= 1'b0;
         rep_q      <= '0;
         err_q      <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef WS2812_FRAME_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         rx_q       <= rx_d;
         sd_q       <= sd_d;
         byte_idx_q <= byte_idx_d;
         gap_q      <= gap_d;
         work_q     <= work_d;
         pend_q     <= pend_d;
         frame_q    <= frame_d;
         pending_q  <= pending_d;
         rep_q      <= rep_d;
         err_q      <= err_d;
         ovr_q      <= ovr_d;
`ifdef WS2812_FRAME_CHECKSUM_EN
         xor_q      <= xor_d;
`endif
      end
   end

   assign o_Start   = (sd_q == SD_START);
   assign o_Frame   = frame_q;
   assign o_Busy    = (rx_q != RX_HUNT);
   assign o_Overrun = ovr_q;
   assign o_Error   = err_q;

endmodule

// File: doc/ws2812_frame_loader.md
Name: ws2812_frame_loader

Overview:
- Upstream feeder for the WS2812 driver. Takes UART RX bytes and assembles a sync-framed packet of NUM_LEDS GRB triplets.
- Double-buffers the assembled frame and hands it to the driver with a start/ready handshake.
- Holds the presented frame stable for the whole serial transmission.
- Sits between the UART receiver and the WS2812 driver in the top level.

Parameters:
- CLOCK_FREQUENCY, 100000000: system clock in Hz; used only to derive the timeout.
- NUM_LEDS, 3: LEDs per frame; frame is NUM_LEDS*24 bits, payload is NUM_LEDS*3 bytes.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_US, 1000: maximum inter-byte gap inside a frame before abort.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte valid.
- i_Rx_Byte  in  8  received UART byte.
- i_Ready  in  1  driver idle flag; asynchronous to i_Clock, so it is synchronised internally.
- o_Start  out  1  one-cycle pulse: driver begins sending o_Frame.
- o_Frame  out  NUM_LEDS*24  frame; LED0 G in the top byte, MSB-first per byte.
- o_Busy  out  1  high while the receive FSM is outside HUNT.
- o_Overrun  out  1  one-cycle pulse when a completed frame overwrites an unsent pending frame.
- o_Error  out  1  one-cycle pulse on timeout abort (or on checksum fail, see feature).

Behaviour:
- Reset (i_Reset_n low at a clock edge):
  - All FSMs go to their idle states; counters are cleared.
  - o_Frame = 0; o_Start, o_Overrun, o_Error = 0; o_Busy = 0; the pending flag is cleared.
  - Reset applied mid-frame or mid-handshake discards everything; no o_Start is issued afterwards.
- i_Ready synchroniser:
  - 2-flop synchroniser to give rdy_s.
  - rdy_s is usable on the third edge after an i_Ready change.
- Receive FSM:
  - HUNT:
    - Ignores every byte except SYNC_BYTE.
    - On SYNC_BYTE: byte_idx = 0, go to PAYLOAD.
  - PAYLOAD:
    - Each i_Rx_DV writes the byte into work_buf at byte position byte_idx, counting from the MSB end.
    - byte_idx then increments.
    - After byte NUM_LEDS*3-1 is written, go to COMMIT.
    - A SYNC_BYTE value inside the payload is treated as data, not as a resync.
  - COMMIT (1 cycle):
    - Copy work_buf to pend_buf.
    - If pending was already 1, pulse o_Overrun (latest frame wins).
    - Set pending = 1; go to HUNT.
  - Timeout:
    - gap_cnt is cleared on every i_Rx_DV.
    - In PAYLOAD, when gap_cnt reaches CLOCK_FREQUENCY/1000000*TIMEOUT_US - 1: pulse o_Error, discard the partial frame, go to HUNT.
    - The counter is sized with $clog2 and saturates outside PAYLOAD.
- Send FSM:
  - IDLE:
    - If pending && rdy_s: o_Frame <= pend_buf, pending <= 0, go to START.
    - If COMMIT occurs in this same cycle, COMMIT wins: pending stays 1 with the new data, and the transfer waits one cycle.
  - START:
    - o_Start = 1 for exactly one cycle.
    - Go to WAIT_LO.
  - WAIT_LO:
    - Wait for rdy_s == 0 (driver accepted).
    - Re-pulse o_Start every 64 cycles until it is accepted, because the driver samples on its own slower clock.
  - WAIT_HI:
    - Wait for rdy_s == 1, then go to IDLE.
    - o_Frame is held constant from START through WAIT_HI.
- Independence: receive and send FSMs run concurrently. A new frame may be received while one is being transmitted.
- Latency: from the last payload byte strobe to o_Start is 3 cycles when the driver is idle (COMMIT, IDLE transfer, START).

Optional Feature:
- Macro: WS2812_FRAME_CHECKSUM_EN.
- When defined:
  - One extra byte follows the payload: the XOR of all payload bytes.
  - The receive FSM gains a CHECK state between PAYLOAD and COMMIT.
  - Mismatch: pulse o_Error, drop the frame, go to HUNT, leave pending unchanged.
  - The timeout also applies while waiting for the checksum byte.
- When undefined: no checksum byte; PAYLOAD goes directly to COMMIT; no XOR logic.

Decomposition:
- Package ws2812_pkg:
  - SYNC_BYTE default.
  - Receive-state localparams: HUNT, PAYLOAD, CHECK, COMMIT.
  - Send-state localparams: IDLE, START, WAIT_LO, WAIT_HI.
  - Bits-per-LED constant = 24.
- One natural sub-module: ws2812_ready_sync (2-flop synchroniser with synchronous active-low reset, output cleared to 0 in reset).

Test Plan:
- Reset, i_Ready = 1, send A5 then 01 02 03 04 05 06 07 08 09 -> after the third edge following the last byte, o_Start pulses once and o_Frame = 72'h010203040506070809.
- Bytes 11 22 then A5 then 9 bytes -> the leading 11 and 22 are ignored; the frame equals the 9 bytes after A5.
- A5, 4 bytes, idle for 100001 cycles (defaults) -> o_Error pulses; no o_Start; a following full frame is accepted normally.
- i_Ready held 0, two complete frames sent -> o_Overrun pulses on the second; raising i_Ready produces a single o_Start with the second frame.
- During WAIT_HI, a new frame arrives -> o_Frame unchanged until i_Ready returns to 1; a second o_Start follows with the new data.
- With WS2812_FRAME_CHECKSUM_EN: A5, 01..09, checksum 01 -> accepted (XOR of 01..09 = 01). Checksum 00 -> o_Error pulses and no o_Start.
